// File: rtl/commit_arbiter.sv
// Multi-channel commit arbiter: per-channel result FIFOs feeding one register-file write port.
// Define COMMIT_ARB_RR_EN for round-robin arbitration; otherwise the highest channel index wins.
module commit_arbiter #(
    parameter int unsigned NUM_CH = 6,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned RN_W   = 6,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         in_valid,
    output logic [NUM_CH-1:0]         in_ready,
    input  logic [NUM_CH*RN_W-1:0]    in_rn,
    input  logic [NUM_CH*DATA_W-1:0]  in_data,
    output logic                      write_en,
    output logic [RN_W-1:0]           write_rn,
    output logic [DATA_W-1:0]         write_data,
    output logic [$clog2(NUM_CH)-1:0] write_ch,
    output logic [NUM_CH-1:0]         pending
);

    localparam int unsigned CH_W  = $clog2(NUM_CH);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [CNT_W-1:0]  count_q  [NUM_CH];
    logic [CNT_W-1:0]  count_d  [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr_q [NUM_CH];
    logic [PTR_W-1:0]  rd_ptr_d [NUM_CH];
    logic [PTR_W-1:0]  wr_ptr_q [NUM_CH];
    logic [PTR_W-1:0]  wr_ptr_d [NUM_CH];
    logic [RN_W-1:0]   mem_rn_q   [NUM_CH][DEPTH];
    logic [DATA_W-1:0] mem_data_q [NUM_CH][DEPTH];

    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic              grant_valid;
    logic [CH_W-1:0]   grant_idx;
    logic [RN_W-1:0]   head_rn;
    logic [DATA_W-1:0] head_data;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready and pending come only from registered counts: no same-cycle pop feeds ready.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            in_ready[i] = (count_q[i] != CNT_W'(DEPTH));
            pending[i]  = (count_q[i] != '0);
        end
    end

    // Writes to r0 complete the handshake but are never buffered.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            push[i] = in_valid[i] & in_ready[i] & (in_rn[i*RN_W +: RN_W] != '0);
        end
    end

`ifdef COMMIT_ARB_RR_EN
    logic [CH_W-1:0] rr_q;
    logic [CH_W-1:0] rr_d;

    always_comb begin
        int unsigned idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            idx = (32'(rr_q) + k) % NUM_CH;
            if (!grant_valid && pending[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = CH_W'(idx);
            end
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (grant_valid) begin
            rr_d = (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + CH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    // Ascending scan so the highest pending index is the last assignment and wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pending[i]) begin
                grant_valid = 1'b1;
                grant_idx   = CH_W'(i);
            end
        end
    end
`endif

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            pop[i] = grant_valid && (grant_idx == CH_W'(i));
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            count_d[i]  = count_q[i];
            rd_ptr_d[i] = rd_ptr_q[i];
            wr_ptr_d[i] = wr_ptr_q[i];
            unique case ({push[i], pop[i]})
                2'b10:   count_d[i] = count_q[i] + CNT_W'(1);
                2'b01:   count_d[i] = count_q[i] - CNT_W'(1);
                default: count_d[i] = count_q[i];
            endcase
            if (push[i]) begin
                wr_ptr_d[i] = ptr_inc(wr_ptr_q[i]);
            end
            if (pop[i]) begin
                rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                count_q[i]  <= '0;
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                count_q[i]  <= count_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
                wr_ptr_q[i] <= wr_ptr_d[i];
            end
        end
    end

    // Storage needs no reset: validity is carried entirely by the counts.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) begin
                mem_rn_q[i][wr_ptr_q[i]]   <= in_rn[i*RN_W +: RN_W];
                mem_data_q[i][wr_ptr_q[i]] <= in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        head_rn   = mem_rn_q[grant_idx][rd_ptr_q[grant_idx]];
        head_data = mem_data_q[grant_idx][rd_ptr_q[grant_idx]];
    end

    // write_ch keeps the last winner through idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_en   <= 1'b0;
            write_rn   <= '0;
            write_data <= '0;
            write_ch   <= '0;
        end else begin
            write_en   <= grant_valid;
            write_rn   <= grant_valid ? head_rn : '0;
            write_data <= grant_valid ? head_data : '0;
            if (grant_valid) begin
                write_ch <= grant_idx;
            end
        end
    end

    a_pop_only_pending: assert property (@(posedge clk) disable iff (!rst_n)
        (pop & ~pending) == '0);

endmodule
